audio_lockstep_checker: RTL and testbench
=========================================

Name: audio_lockstep_checker

Overview:
Synthesisable, parametrised multi-channel output checker for the FM radio datapath. It drains CHANNELS audio FIFOs in lockstep, popping all of them in the same cycle only when every one is non-empty. Each popped sample is compared against a golden sample stream supplied through its own FIFO. The block counts samples and per-channel mismatches, stops after NUM_SAMPLES, and flags done. It is the on-chip, N-channel successor of the left/right drain-and-compare bench logic, and is used for BIST and FPGA bring-up.

Parameters:
CHANNELS, 2, number of audio channels drained in lockstep (≥1)
DATA_SIZE, 32, signed sample width
NUM_SAMPLES, 25, lockstep pops per run (0 allowed)
CNT_WIDTH, 16, width of the sample and error counters

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
chan_dout  in  CHANNELS*DATA_SIZE  channel c occupies bits [c*DATA_SIZE +: DATA_SIZE]; first-word-fall-through
chan_empty  in  CHANNELS  per-channel FIFO empty
chan_rd_en  out  CHANNELS  per-channel pop
exp_dout  in  CHANNELS*DATA_SIZE  golden samples, same packing
exp_empty  in  1  golden FIFO empty
exp_rd_en  out  1  golden pop
busy  out  1  high in RUN
done  out  1  high in DONE
sample_count  out  CNT_WIDTH  lockstep pops this run
error_count  out  CHANNELS*CNT_WIDTH  per-channel mismatch counts
total_errors  out  CNT_WIDTH  sum of mismatches across channels, saturating
mismatch  out  1  registered pulse: previous pop had ≥1 mismatch
mismatch_mask  out  CHANNELS  registered per-channel mismatch bits of the previous pop

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs and counters 0; chan_rd_en and exp_rd_en are 0.
- FSM states are IDLE, RUN and DONE.
- IDLE + start: clear all counters, mismatch and mismatch_mask, then enter RUN.
- DONE + start: same as IDLE + start.
- start while in RUN is ignored.
- pop is combinational: state==RUN, &(~chan_empty), ~exp_empty, and sample_count < NUM_SAMPLES.
- chan_rd_en = {CHANNELS{pop}}; exp_rd_en = pop. Pops happen in the same cycle as the condition. No partial pops: if any single FIFO is empty, nothing is popped.
- Compare: mm[c] = (chan_dout[c] != exp_dout[c]). The comparison is full-width and exact, including the sign bit.
- On the clock edge that ends a pop cycle:
  - sample_count += 1.
  - error_count[c] += mm[c], saturating at all-ones.
  - total_errors += popcount(mm), saturating.
  - mismatch <= |mm; mismatch_mask <= mm.
- On a non-pop cycle, mismatch and mismatch_mask return to 0, so both are single-cycle pulses.
- Latency: counters reflect a pop 1 cycle after the pop cycle; mismatch and mismatch_mask are valid that same cycle.
- RUN → DONE on the edge where sample_count becomes NUM_SAMPLES. When NUM_SAMPLES=0, RUN → DONE on the first RUN cycle with no pops.
- done stays high and counters hold in DONE until the next start.
- A reset assertion mid-run aborts immediately. FIFO contents are not this block's concern.
- Arithmetic: counters are unsigned; popcount is computed at clog2(CHANNELS+1) bits and zero-extended before the add.

Optional Feature:
FIRST_ERR_CAPTURE_EN
- Defined: adds the following outputs:
  - first_err_valid (1)
  - first_err_index (CNT_WIDTH): sample_count value at the failing pop, 0-based
  - first_err_mask (CHANNELS)
  - first_err_got (CHANNELS*DATA_SIZE)
  - first_err_exp (CHANNELS*DATA_SIZE)
- These are loaded on the first mismatching pop of a run and hold until the next start or reset. All reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- CHANNELS=2, NUM_SAMPLES=25, all FIFOs pre-filled with 25 identical samples, start → 25 pops on consecutive cycles; done 1 cycle after the 25th pop; sample_count=25, error_count={0,0}, total_errors=0.
- Same setup, but channel 1 sample 7 = 0xFFFFFFFE vs expected 0x00000002 → single mismatch pulse with mismatch_mask=2'b10 one cycle after pop 8; error_count[1]=1, total_errors=1. With FIRST_ERR_CAPTURE_EN: first_err_index=7, got=0xFFFFFFFE, exp=0x00000002.
- Channel 0 empty for 5 cycles while channel 1 and the golden FIFO are non-empty → chan_rd_en=0 and exp_rd_en=0 throughout; pops resume in lockstep when channel 0 refills; no sample skew.
- Reset pulsed low mid-run at sample 10 → all outputs 0 immediately; a new start runs a full 25 samples.
- NUM_SAMPLES=0, start → no rd_en ever asserted; done on the second cycle after start.
- CNT_WIDTH=4, 20 mismatching samples on channel 0 → error_count[0] and total_errors saturate at 15.

Source files
------------

// File: rtl/audio_lockstep_checker_if.sv
// FIFO-side bundle for audio_lockstep_checker: CHANNELS audio FIFOs plus one golden FIFO.
// The master drives FIFO data/empty flags; the slave (the checker) issues the pops.
interface audio_lockstep_checker_if #(
  parameter int CHANNELS  = 2,
  parameter int DATA_SIZE = 32
);
  logic [CHANNELS*DATA_SIZE-1:0] chan_dout;
  logic [CHANNELS-1:0]           chan_empty;
  logic [CHANNELS-1:0]           chan_rd_en;
  logic [CHANNELS*DATA_SIZE-1:0] exp_dout;
  logic                          exp_empty;
  logic                          exp_rd_en;

  modport master (
    output chan_dout, chan_empty, exp_dout, exp_empty,
    input  chan_rd_en, exp_rd_en
  );

  modport slave (
    input  chan_dout, chan_empty, exp_dout, exp_empty,
    output chan_rd_en, exp_rd_en
  );
endinterface

// File: rtl/audio_lockstep_checker.sv
// Lockstep N-channel drain-and-compare checker against a golden FIFO stream.
// Optional FIRST_ERR_CAPTURE_EN adds capture of the first mismatching pop of a run.
module audio_lockstep_checker #(
  parameter int CHANNELS    = 2,
  parameter int DATA_SIZE   = 32,
  parameter int NUM_SAMPLES = 25,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  audio_lockstep_checker_if.slave       fifo,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_WIDTH-1:0]          sample_count,
  output logic [CHANNELS*CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0]          total_errors,
  output logic                          mismatch,
  output logic [CHANNELS-1:0]           mismatch_mask
`ifdef FIRST_ERR_CAPTURE_EN
  ,
  output logic                          first_err_valid,
  output logic [CNT_WIDTH-1:0]          first_err_index,
  output logic [CHANNELS-1:0]           first_err_mask,
  output logic [CHANNELS*DATA_SIZE-1:0] first_err_got,
  output logic [CHANNELS*DATA_SIZE-1:0] first_err_exp
`endif
);

  localparam int PC_W  = $clog2(CHANNELS + 1);
  localparam int NS_W  = (NUM_SAMPLES > 0) ? $clog2(NUM_SAMPLES + 1) : 1;
  // The run counter is wide enough for NUM_SAMPLES even if CNT_WIDTH is not.
  localparam int RUN_W = (NS_W > CNT_WIDTH) ? NS_W : CNT_WIDTH;
  localparam int SUM_W = ((PC_W > CNT_WIDTH) ? PC_W : CNT_WIDTH) + 1;

  localparam logic [RUN_W-1:0]     NUM_LIMIT = RUN_W'(NUM_SAMPLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_reg;
  logic [1:0]           state_next;
  logic [RUN_W-1:0]     run_cnt_reg;
  logic [CNT_WIDTH-1:0] total_reg;
  logic [CNT_WIDTH-1:0] total_next;
  logic [SUM_W-1:0]     total_sum;
  logic                 mismatch_reg;
  logic [CHANNELS-1:0]  mask_reg;
  logic [CHANNELS-1:0]  mm;
  logic [PC_W-1:0]      mm_count;
  logic                 pop;
  logic                 restart;

  assign restart = start && (state_reg != ST_RUN);

  // Pop only when every FIFO, including the golden one, can supply a word.
  assign pop = (state_reg == ST_RUN) && (&(~fifo.chan_empty)) && !fifo.exp_empty &&
               (run_cnt_reg < NUM_LIMIT);

  assign fifo.chan_rd_en = {CHANNELS{pop}};
  assign fifo.exp_rd_en  = pop;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_cmp
      assign mm[gi] = (fifo.chan_dout[gi*DATA_SIZE +: DATA_SIZE] !=
                       fifo.exp_dout[gi*DATA_SIZE +: DATA_SIZE]);
    end
  endgenerate

  always_comb begin
    mm_count = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mm_count = mm_count + PC_W'(mm[c]);
    end
  end

  assign total_sum  = SUM_W'(total_reg) + SUM_W'(mm_count);
  assign total_next = (total_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : total_sum[CNT_WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Without a pop this only fires when NUM_SAMPLES is already reached (NUM_SAMPLES=0).
        if (pop ? (run_cnt_reg + RUN_W'(1) == NUM_LIMIT) : (run_cnt_reg >= NUM_LIMIT))
          state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      run_cnt_reg  <= '0;
      total_reg    <= '0;
      mismatch_reg <= 1'b0;
      mask_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (restart) begin
        run_cnt_reg  <= '0;
        total_reg    <= '0;
        mismatch_reg <= 1'b0;
        mask_reg     <= '0;
      end else begin
        mismatch_reg <= pop && (|mm);
        mask_reg     <= pop ? mm : '0;
        if (pop) begin
          run_cnt_reg <= run_cnt_reg + RUN_W'(1);
          total_reg   <= total_next;
        end
      end
    end
  end

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_err
      logic [CNT_WIDTH-1:0] cnt_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (restart) begin
          cnt_reg <= '0;
        end else if (pop && mm[gi] && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign error_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
    end
  endgenerate

`ifdef FIRST_ERR_CAPTURE_EN
  logic                          fe_valid_reg;
  logic [CNT_WIDTH-1:0]          fe_index_reg;
  logic [CHANNELS-1:0]           fe_mask_reg;
  logic [CHANNELS*DATA_SIZE-1:0] fe_got_reg;
  logic [CHANNELS*DATA_SIZE-1:0] fe_exp_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fe_valid_reg <= 1'b0;
      fe_index_reg <= '0;
      fe_mask_reg  <= '0;
      fe_got_reg   <= '0;
      fe_exp_reg   <= '0;
    end else if (restart) begin
      fe_valid_reg <= 1'b0;
      fe_index_reg <= '0;
      fe_mask_reg  <= '0;
      fe_got_reg   <= '0;
      fe_exp_reg   <= '0;
    end else if (pop && (|mm) && !fe_valid_reg) begin
      fe_valid_reg <= 1'b1;
      fe_index_reg <= sample_count;
      fe_mask_reg  <= mm;
      fe_got_reg   <= fifo.chan_dout;
      fe_exp_reg   <= fifo.exp_dout;
    end
  end

  assign first_err_valid = fe_valid_reg;
  assign first_err_index = fe_index_reg;
  assign first_err_mask  = fe_mask_reg;
  assign first_err_got   = fe_got_reg;
  assign first_err_exp   = fe_exp_reg;
`endif

  assign busy          = (state_reg == ST_RUN);
  assign done          = (state_reg == ST_DONE);
  assign sample_count  = (run_cnt_reg > RUN_W'(CNT_MAX)) ? CNT_MAX : run_cnt_reg[CNT_WIDTH-1:0];
  assign total_errors  = total_reg;
  assign mismatch      = mismatch_reg;
  assign mismatch_mask = mask_reg;

endmodule

// File: tb/tb_audio_lockstep_checker.sv
// Directed bench for audio_lockstep_checker: main 2-channel instance with queue FIFOs,
// plus a NUM_SAMPLES=0 instance and a CNT_WIDTH=4 saturation instance.
module tb_audio_lockstep_checker;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic start_m, start_z, start_s;
  int   tests = 0;
  int   fails = 0;

  audio_lockstep_checker_if #(.CHANNELS(2), .DATA_SIZE(32)) mif();
  audio_lockstep_checker_if #(.CHANNELS(2), .DATA_SIZE(32)) zif();
  audio_lockstep_checker_if #(.CHANNELS(2), .DATA_SIZE(32)) sif();

  logic        busy_m, done_m, mismatch_m, busy_z, done_z, mismatch_z, busy_s, done_s, mismatch_s;
  logic [15:0] sc_m, tot_m, sc_z, tot_z;
  logic [31:0] ec_m, ec_z;
  logic [3:0]  sc_s, tot_s;
  logic [7:0]  ec_s;
  logic [1:0]  mask_m, mask_z, mask_s;
`ifdef FIRST_ERR_CAPTURE_EN
  logic        fv_m, fv_z, fv_s;
  logic [15:0] fi_m, fi_z;
  logic [3:0]  fi_s;
  logic [1:0]  fmask_m, fmask_z, fmask_s;
  logic [63:0] fgot_m, fexp_m, fgot_z, fexp_z, fgot_s, fexp_s;
`endif

  audio_lockstep_checker #(.CHANNELS(2), .DATA_SIZE(32), .NUM_SAMPLES(25), .CNT_WIDTH(16)) dut_m (
    .clock(clock), .reset(reset), .start(start_m), .fifo(mif.slave),
    .busy(busy_m), .done(done_m), .sample_count(sc_m), .error_count(ec_m),
    .total_errors(tot_m), .mismatch(mismatch_m), .mismatch_mask(mask_m)
`ifdef FIRST_ERR_CAPTURE_EN
    , .first_err_valid(fv_m), .first_err_index(fi_m), .first_err_mask(fmask_m),
    .first_err_got(fgot_m), .first_err_exp(fexp_m)
`endif
  );

  audio_lockstep_checker #(.CHANNELS(2), .DATA_SIZE(32), .NUM_SAMPLES(0), .CNT_WIDTH(16)) dut_z (
    .clock(clock), .reset(reset), .start(start_z), .fifo(zif.slave),
    .busy(busy_z), .done(done_z), .sample_count(sc_z), .error_count(ec_z),
    .total_errors(tot_z), .mismatch(mismatch_z), .mismatch_mask(mask_z)
`ifdef FIRST_ERR_CAPTURE_EN
    , .first_err_valid(fv_z), .first_err_index(fi_z), .first_err_mask(fmask_z),
    .first_err_got(fgot_z), .first_err_exp(fexp_z)
`endif
  );

  audio_lockstep_checker #(.CHANNELS(2), .DATA_SIZE(32), .NUM_SAMPLES(20), .CNT_WIDTH(4)) dut_s (
    .clock(clock), .reset(reset), .start(start_s), .fifo(sif.slave),
    .busy(busy_s), .done(done_s), .sample_count(sc_s), .error_count(ec_s),
    .total_errors(tot_s), .mismatch(mismatch_s), .mismatch_mask(mask_s)
`ifdef FIRST_ERR_CAPTURE_EN
    , .first_err_valid(fv_s), .first_err_index(fi_s), .first_err_mask(fmask_s),
    .first_err_got(fgot_s), .first_err_exp(fexp_s)
`endif
  );

  // ---------------- FIFO model for the main instance ----------------
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [63:0] qe[$];
  logic [1:0]  block     = 2'b00;
  logic [1:0]  pop_ch_l  = 2'b00;
  logic        pop_exp_l = 1'b0;
  logic        z_rd_seen = 1'b0;

  task automatic drive_fifos();
    mif.chan_dout  = {(q1.size() > 0) ? q1[0] : 32'h0, (q0.size() > 0) ? q0[0] : 32'h0};
    mif.chan_empty = {block[1] || (q1.size() == 0), block[0] || (q0.size() == 0)};
    mif.exp_dout   = (qe.size() > 0) ? qe[0] : 64'h0;
    mif.exp_empty  = (qe.size() == 0);
  endtask

  always @(negedge clock) begin
    pop_ch_l  = mif.chan_rd_en;
    pop_exp_l = mif.exp_rd_en;
    if (zif.chan_rd_en != 2'b00 || zif.exp_rd_en) z_rd_seen = 1'b1;
  end

  initial begin
    drive_fifos();
    forever begin
      @(posedge clock);
      #1;
      if (pop_ch_l[0] && q0.size() > 0) void'(q0.pop_front());
      if (pop_ch_l[1] && q1.size() > 0) void'(q1.pop_front());
      if (pop_exp_l && qe.size() > 0) void'(qe.pop_front());
      drive_fifos();
    end
  end

  initial begin
    zif.chan_dout = 64'h0; zif.chan_empty = 2'b00; zif.exp_dout = 64'h0; zif.exp_empty = 1'b0;
    // Channel 0 always differs from golden, channel 1 always matches.
    sif.chan_dout = {32'd5, 32'd1}; sif.chan_empty = 2'b00;
    sif.exp_dout  = {32'd5, 32'd0}; sif.exp_empty  = 1'b0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] sample(input int c, input int i);
    return 32'(i * 3 + c * 100 - 7);
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic fill(input int inj_idx, input logic [1:0] inj_mask,
                      input logic [31:0] got, input logic [31:0] expv);
    logic [31:0] g0, g1, e0, e1;
    q0.delete(); q1.delete(); qe.delete();
    for (int i = 0; i < 25; i++) begin
      g0 = sample(0, i); g1 = sample(1, i); e0 = g0; e1 = g1;
      if (i == inj_idx && inj_mask[0]) begin g0 = got; e0 = expv; end
      if (i == inj_idx && inj_mask[1]) begin g1 = got; e1 = expv; end
      q0.push_back(g0); q1.push_back(g1); qe.push_back({e1, e0});
    end
  endtask

  task automatic pulse_start_m();
    start_m = 1'b1;
    step();
    start_m = 1'b0;
  endtask

  // Starts a run and follows it to done; returns pop cycles, mismatch pulses and timing.
  task automatic run_watch(output int pops, output int pulses, output logic [1:0] pmask,
                           output int pidx, output int cycles);
    pops = 0; pulses = 0; pmask = 2'b00; pidx = -1; cycles = 0;
    pulse_start_m();
    forever begin
      if (mismatch_m) begin pulses++; pmask = mask_m; pidx = int'(sc_m); end
      if (done_m || cycles >= 300) break;
      if (mif.chan_rd_en == 2'b11 && mif.exp_rd_en) pops++;
      step();
      cycles++;
    end
    if (cycles >= 300) check("run_timeout", 1, 0);
  endtask

  typedef struct {
    int          inj_idx;
    logic [1:0]  inj_mask;
    logic [31:0] got;
    logic [31:0] expv;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] tot;
    int          pulses;
  } vec_t;

  initial begin
    vec_t        vecs[4];
    int          pops, pulses, pidx, cycles;
    logic [1:0]  pmask;

    vecs[0] = '{-1, 2'b00, 32'h0000_0000, 32'h0000_0000, 16'd0, 16'd0, 16'd0, 0};
    vecs[1] = '{ 7, 2'b10, 32'hFFFF_FFFE, 32'h0000_0002, 16'd0, 16'd1, 16'd1, 1};
    vecs[2] = '{ 0, 2'b01, 32'h8000_0005, 32'h0000_0005, 16'd1, 16'd0, 16'd1, 1};
    vecs[3] = '{24, 2'b11, 32'h7FFF_FFFF, 32'h7FFF_FFFE, 16'd1, 16'd1, 16'd2, 1};

    reset = 1'b0; start_m = 1'b0; start_z = 1'b0; start_s = 1'b0;
    step(); step();
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_sample_count", sc_m, 0);
    check("rst_error_count", ec_m, 0);
    check("rst_total", tot_m, 0);
    check("rst_mismatch", {mismatch_m, mask_m}, 0);
    check("rst_rd_en", {mif.chan_rd_en, mif.exp_rd_en}, 0);
    reset = 1'b1;
    step();
    check("idle_busy", busy_m, 0);
    $display("[TB] reset state checked");

    // NUM_SAMPLES=0: done on the second cycle after start, never a pop.
    start_z = 1'b1; step(); start_z = 1'b0;
    check("z_busy_c1", busy_z, 1);
    check("z_done_c1", done_z, 0);
    step();
    check("z_done_c2", done_z, 1);
    check("z_busy_c2", busy_z, 0);
    check("z_sample_count", sc_z, 0);
    start_z = 1'b1; step(); start_z = 1'b0;
    check("z_restart_from_done", busy_z, 1);
    step();
    check("z_rd_never", z_rd_seen, 0);
    $display("[TB] zero-sample run done=%0b", done_z);

    // CNT_WIDTH=4 saturation over 20 mismatching samples on channel 0.
    begin
      int sp = 0, sc = 0;
      start_s = 1'b1; step(); start_s = 1'b0;
      while (!done_s && sc < 100) begin
        if (sif.exp_rd_en) sp++;
        step();
        sc++;
      end
      check("sat_pops", sp, 20);
      check("sat_err0", ec_s[3:0], 4'hF);
      check("sat_err1", ec_s[7:4], 4'h0);
      check("sat_total", tot_s, 4'hF);
      $display("[TB] saturation run pops=%0d err0=%0d total=%0d", sp, ec_s[3:0], tot_s);
    end

    // Table-driven full runs on the main instance.
    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].inj_idx, vecs[v].inj_mask, vecs[v].got, vecs[v].expv);
      run_watch(pops, pulses, pmask, pidx, cycles);
      check($sformatf("v%0d_pops", v), pops, 25);
      check($sformatf("v%0d_done_latency", v), cycles, 25);
      check($sformatf("v%0d_done", v), done_m, 1);
      check($sformatf("v%0d_sample_count", v), sc_m, 25);
      check($sformatf("v%0d_err0", v), ec_m[15:0], vecs[v].e0);
      check($sformatf("v%0d_err1", v), ec_m[31:16], vecs[v].e1);
      check($sformatf("v%0d_total", v), tot_m, vecs[v].tot);
      check($sformatf("v%0d_pulses", v), pulses, vecs[v].pulses);
      if (vecs[v].pulses > 0) begin
        check($sformatf("v%0d_pulse_mask", v), pmask, vecs[v].inj_mask);
        check($sformatf("v%0d_pulse_time", v), pidx, vecs[v].inj_idx + 1);
      end
`ifdef FIRST_ERR_CAPTURE_EN
      check($sformatf("v%0d_fe_valid", v), fv_m, (vecs[v].pulses > 0));
      if (vecs[v].pulses > 0) begin
        check($sformatf("v%0d_fe_index", v), fi_m, vecs[v].inj_idx);
        check($sformatf("v%0d_fe_mask", v), fmask_m, vecs[v].inj_mask);
        check($sformatf("v%0d_fe_got", v), fgot_m,
              {vecs[v].inj_mask[1] ? vecs[v].got : sample(1, vecs[v].inj_idx),
               vecs[v].inj_mask[0] ? vecs[v].got : sample(0, vecs[v].inj_idx)});
        check($sformatf("v%0d_fe_exp", v), fexp_m,
              {vecs[v].inj_mask[1] ? vecs[v].expv : sample(1, vecs[v].inj_idx),
               vecs[v].inj_mask[0] ? vecs[v].expv : sample(0, vecs[v].inj_idx)});
      end
`endif
      $display("[TB] vector %0d pops=%0d cycles=%0d err0=%0d err1=%0d total=%0d pulses=%0d",
               v, pops, cycles, ec_m[15:0], ec_m[31:16], tot_m, pulses);
    end

    // Channel 0 stalls mid-run: no partial pops, lockstep resumes without skew.
    fill(-1, 2'b00, 32'h0, 32'h0);
    pulse_start_m();
    step(); step(); step();
    block[0] = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_rd_en_c%0d", k), {mif.chan_rd_en, mif.exp_rd_en}, 0);
      step();
    end
    block[0] = 1'b0;
    begin
      int wc = 0;
      while (!done_m && wc < 200) begin step(); wc++; end
      check("stall_done", done_m, 1);
    end
    check("stall_sample_count", sc_m, 25);
    check("stall_errors", ec_m, 0);
    check("stall_total", tot_m, 0);
    check("stall_fifos_drained", q0.size() + q1.size() + qe.size(), 0);
    $display("[TB] stall run sample_count=%0d total=%0d", sc_m, tot_m);

    // Asynchronous reset mid-run, then a clean full run.
    fill(-1, 2'b00, 32'h0, 32'h0);
    pulse_start_m();
    begin
      int wc = 0;
      while (sc_m != 16'd10 && wc < 100) begin step(); wc++; end
      check("midrun_reached_10", sc_m, 10);
    end
    reset = 1'b0;
    #1;
    check("midrun_rst_busy", busy_m, 0);
    check("midrun_rst_sample_count", sc_m, 0);
    check("midrun_rst_counts", {ec_m, tot_m}, 0);
    check("midrun_rst_rd_en", {mif.chan_rd_en, mif.exp_rd_en}, 0);
    step(); step();
    fill(-1, 2'b00, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    run_watch(pops, pulses, pmask, pidx, cycles);
    check("after_rst_pops", pops, 25);
    check("after_rst_sample_count", sc_m, 25);
    check("after_rst_total", tot_m, 0);
    $display("[TB] post-reset run pops=%0d sample_count=%0d", pops, sc_m);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
